// File: rtl/onedconv_sched_if.sv
// Pixel/config/handshake bundle between the front end (master) and onedconv_sched (slave).
// Rows/Row_Idx are present only when ONEDCONV_SCHED_ROWCNT_EN is defined.
interface onedconv_sched_if #(
  parameter int BITWIDTH_OF_COLUMS = 11,
  parameter int BITWIDTH_OF_KERNEL = 3
`ifdef ONEDCONV_SCHED_ROWCNT_EN
  ,
  parameter int BITWIDTH_OF_ROWS = 11
`endif
);
  logic                          ONEDCONV_SCHED_Start;
  logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_SCHED_Img_Colums;
  logic [BITWIDTH_OF_KERNEL-1:0] ONEDCONV_SCHED_Kernel_W;
  logic [BITWIDTH_OF_KERNEL-1:0] ONEDCONV_SCHED_Stride;
  logic                          ONEDCONV_SCHED_Pix_Valid;
  logic                          ONEDCONV_SCHED_Out_Full;
  logic                          ONEDCONV_SCHED_Pix_Ready;
  logic                          ONEDCONV_SCHED_Conv_En;
  logic                          ONEDCONV_SCHED_Eqcw;
  logic                          ONEDCONV_SCHED_Eqst;
  logic                          ONEDCONV_SCHED_Conv_Clr;
  logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_SCHED_Of_Colums;
  logic                          ONEDCONV_SCHED_Busy;
  logic                          ONEDCONV_SCHED_Done;
  logic                          ONEDCONV_SCHED_Err;
`ifdef ONEDCONV_SCHED_ROWCNT_EN
  logic [BITWIDTH_OF_ROWS-1:0]   ONEDCONV_SCHED_Rows;
  logic [BITWIDTH_OF_ROWS-1:0]   ONEDCONV_SCHED_Row_Idx;
`endif

  modport master (
`ifdef ONEDCONV_SCHED_ROWCNT_EN
    output ONEDCONV_SCHED_Rows,
    input  ONEDCONV_SCHED_Row_Idx,
`endif
    output ONEDCONV_SCHED_Start, ONEDCONV_SCHED_Img_Colums, ONEDCONV_SCHED_Kernel_W,
    output ONEDCONV_SCHED_Stride, ONEDCONV_SCHED_Pix_Valid, ONEDCONV_SCHED_Out_Full,
    input  ONEDCONV_SCHED_Pix_Ready, ONEDCONV_SCHED_Conv_En, ONEDCONV_SCHED_Eqcw,
    input  ONEDCONV_SCHED_Eqst, ONEDCONV_SCHED_Conv_Clr, ONEDCONV_SCHED_Of_Colums,
    input  ONEDCONV_SCHED_Busy, ONEDCONV_SCHED_Done, ONEDCONV_SCHED_Err
  );

  modport slave (
`ifdef ONEDCONV_SCHED_ROWCNT_EN
    input  ONEDCONV_SCHED_Rows,
    output ONEDCONV_SCHED_Row_Idx,
`endif
    input  ONEDCONV_SCHED_Start, ONEDCONV_SCHED_Img_Colums, ONEDCONV_SCHED_Kernel_W,
    input  ONEDCONV_SCHED_Stride, ONEDCONV_SCHED_Pix_Valid, ONEDCONV_SCHED_Out_Full,
    output ONEDCONV_SCHED_Pix_Ready, ONEDCONV_SCHED_Conv_En, ONEDCONV_SCHED_Eqcw,
    output ONEDCONV_SCHED_Eqst, ONEDCONV_SCHED_Conv_Clr, ONEDCONV_SCHED_Of_Colums,
    output ONEDCONV_SCHED_Busy, ONEDCONV_SCHED_Done, ONEDCONV_SCHED_Err
  );
endinterface

// File: rtl/onedconv_sched.sv
// Row scheduler for the 1-D convolution datapath: output-column count by iterative
// subtraction, pixel pacing and set-enable strobes. Multi-row mode: ONEDCONV_SCHED_ROWCNT_EN.
module onedconv_sched #(
  parameter int BITWIDTH_OF_COLUMS = 11,
  parameter int BITWIDTH_OF_KERNEL = 3
`ifdef ONEDCONV_SCHED_ROWCNT_EN
  ,
  parameter int BITWIDTH_OF_ROWS = 11
`endif
) (
  input  logic             ONEDCONV_SCHED_clk,
  input  logic             ONEDCONV_SCHED_Clr,
  onedconv_sched_if.slave  bus
);
  localparam int CW = BITWIDTH_OF_COLUMS;
  localparam int KW = BITWIDTH_OF_KERNEL;

  typedef enum logic [2:0] {IDLE, CALC, CLR, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   c_q, rem_q, of_q, col_q;
  logic [KW-1:0]   k_q, s_q, st_q;
  logic            err_q;
  logic [CW-1:0]   k_ext, s_ext;
  logic            start_ok, pix_ready, accept, cfg_bad, rem_ge_s;
  logic            last_col, in_stride, st_wrap;
`ifdef ONEDCONV_SCHED_ROWCNT_EN
  localparam int RW = BITWIDTH_OF_ROWS;
  logic [RW-1:0]   rows_q, row_q;
  logic            last_row;
`endif

  assign k_ext     = CW'(k_q);
  assign s_ext     = CW'(s_q);
  assign start_ok  = (state_q == IDLE) & bus.ONEDCONV_SCHED_Start;
  assign pix_ready = (state_q == RUN) & ~bus.ONEDCONV_SCHED_Out_Full;
  assign accept    = pix_ready & bus.ONEDCONV_SCHED_Pix_Valid;
  assign rem_ge_s  = (rem_q >= s_ext);
  assign last_col  = (col_q == (c_q - CW'(1)));
  assign in_stride = (col_q >= k_ext);
  assign st_wrap   = (st_q == (s_q - KW'(1)));
`ifdef ONEDCONV_SCHED_ROWCNT_EN
  assign last_row  = (row_q == (rows_q - RW'(1)));
  assign cfg_bad   = (k_q == '0) | (s_q == '0) | (c_q < k_ext) | (rows_q == '0);
`else
  assign cfg_bad   = (k_q == '0) | (s_q == '0) | (c_q < k_ext);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.ONEDCONV_SCHED_Start) state_d = CALC;
      CALC: begin
        if (cfg_bad)        state_d = DONE;
        else if (!rem_ge_s) state_d = CLR;
      end
      CLR:  state_d = RUN;
      RUN: begin
        if (accept && last_col) begin
`ifdef ONEDCONV_SCHED_ROWCNT_EN
          state_d = last_row ? DONE : CLR;
`else
          state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched configuration and the subtraction remainder need no reset: only
  // read in CALC/RUN, which are always entered through a Start latch.
  always_ff @(posedge ONEDCONV_SCHED_clk) begin
    if (start_ok) begin
      c_q   <= bus.ONEDCONV_SCHED_Img_Colums;
      k_q   <= bus.ONEDCONV_SCHED_Kernel_W;
      s_q   <= bus.ONEDCONV_SCHED_Stride;
      rem_q <= bus.ONEDCONV_SCHED_Img_Colums - CW'(bus.ONEDCONV_SCHED_Kernel_W);
`ifdef ONEDCONV_SCHED_ROWCNT_EN
      rows_q <= bus.ONEDCONV_SCHED_Rows;
`endif
    end else if ((state_q == CALC) && !cfg_bad && rem_ge_s) begin
      rem_q <= rem_q - s_ext;
    end
  end

  always_ff @(posedge ONEDCONV_SCHED_clk or negedge ONEDCONV_SCHED_Clr) begin
    if (!ONEDCONV_SCHED_Clr) begin
      state_q <= IDLE;
      of_q    <= '0;
      err_q   <= 1'b0;
      col_q   <= '0;
      st_q    <= '0;
`ifdef ONEDCONV_SCHED_ROWCNT_EN
      row_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        err_q <= 1'b0;
        of_q  <= CW'(1);
`ifdef ONEDCONV_SCHED_ROWCNT_EN
        row_q <= '0;
`endif
      end
      if (state_q == CALC) begin
        if (cfg_bad) begin
          err_q <= 1'b1;
          of_q  <= '0;
        end else if (rem_ge_s) begin
          of_q  <= of_q + CW'(1);
        end
      end
      if (state_q == CLR) begin
        col_q <= '0;
        st_q  <= '0;
      end
      // Stride phase only advances once the first window has filled.
      if (accept) begin
        col_q <= col_q + CW'(1);
        if (in_stride) st_q <= st_wrap ? '0 : (st_q + KW'(1));
`ifdef ONEDCONV_SCHED_ROWCNT_EN
        if (last_col && !last_row) row_q <= row_q + RW'(1);
`endif
      end
    end
  end

  assign bus.ONEDCONV_SCHED_Pix_Ready = pix_ready;
  assign bus.ONEDCONV_SCHED_Conv_En   = accept;
  assign bus.ONEDCONV_SCHED_Eqcw      = accept & (col_q == (k_ext - CW'(1)));
  assign bus.ONEDCONV_SCHED_Eqst      = accept & in_stride & st_wrap;
  assign bus.ONEDCONV_SCHED_Conv_Clr  = (state_q != CLR);
  assign bus.ONEDCONV_SCHED_Of_Colums = of_q;
  assign bus.ONEDCONV_SCHED_Busy      = (state_q != IDLE);
  assign bus.ONEDCONV_SCHED_Done      = (state_q == DONE);
  assign bus.ONEDCONV_SCHED_Err       = err_q;
`ifdef ONEDCONV_SCHED_ROWCNT_EN
  assign bus.ONEDCONV_SCHED_Row_Idx   = row_q;
`endif
endmodule

// File: tb/tb_onedconv_sched.sv
// Self-checking bench for onedconv_sched: row-level reference model checked every cycle,
// plus directed rows with hand-computed totals. Honours ONEDCONV_SCHED_ROWCNT_EN.
module tb_onedconv_sched;
  localparam int CW = 11;
  localparam int KW = 3;
  localparam int RW = 11;
  localparam int P_IDLE = 0, P_CALC = 1, P_CLR = 2, P_RUN = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ONEDCONV_SCHED_ROWCNT_EN
  onedconv_sched_if #(.BITWIDTH_OF_COLUMS(CW), .BITWIDTH_OF_KERNEL(KW), .BITWIDTH_OF_ROWS(RW)) bus ();
  onedconv_sched #(.BITWIDTH_OF_COLUMS(CW), .BITWIDTH_OF_KERNEL(KW), .BITWIDTH_OF_ROWS(RW)) dut (
    .ONEDCONV_SCHED_clk(clk), .ONEDCONV_SCHED_Clr(rst_n), .bus(bus));
`else
  onedconv_sched_if #(.BITWIDTH_OF_COLUMS(CW), .BITWIDTH_OF_KERNEL(KW)) bus ();
  onedconv_sched #(.BITWIDTH_OF_COLUMS(CW), .BITWIDTH_OF_KERNEL(KW)) dut (
    .ONEDCONV_SCHED_clk(clk), .ONEDCONV_SCHED_Clr(rst_n), .bus(bus));
`endif

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: row-level view of the scheduler
  int m_phase = P_IDLE, m_left = 0, m_acc = 0, m_row = 0;
  int m_C = 0, m_K = 0, m_S = 0, m_R = 1, m_of = 0;
  bit m_err = 1'b0, m_valid = 1'b0;
  int cnt_eqcw = 0, cnt_eqst = 0, cnt_done = 0, cnt_clr = 0, cnt_en = 0;
  int cnt_rdy = 0, cnt_en_full = 0, cnt_calc = 0, cnt_busy = 0;
  bit e_rdy, e_acc, e_cw, e_st;
  int n;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = P_IDLE; m_of = 0; m_err = 1'b0; m_row = 0; m_acc = 0;
        check("rst_pix_ready", int'(bus.ONEDCONV_SCHED_Pix_Ready), 0);
        check("rst_conv_en",   int'(bus.ONEDCONV_SCHED_Conv_En), 0);
        check("rst_eqcw",      int'(bus.ONEDCONV_SCHED_Eqcw), 0);
        check("rst_eqst",      int'(bus.ONEDCONV_SCHED_Eqst), 0);
        check("rst_conv_clr",  int'(bus.ONEDCONV_SCHED_Conv_Clr), 1);
        check("rst_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 0);
        check("rst_busy",      int'(bus.ONEDCONV_SCHED_Busy), 0);
        check("rst_done",      int'(bus.ONEDCONV_SCHED_Done), 0);
        check("rst_err",       int'(bus.ONEDCONV_SCHED_Err), 0);
`ifdef ONEDCONV_SCHED_ROWCNT_EN
        check("rst_row_idx",   int'(bus.ONEDCONV_SCHED_Row_Idx), 0);
`endif
      end else begin
        e_rdy = (m_phase == P_RUN) && !bus.ONEDCONV_SCHED_Out_Full;
        e_acc = e_rdy && bus.ONEDCONV_SCHED_Pix_Valid;
        n     = m_acc + 1;
        e_cw  = e_acc && (n == m_K);
        e_st  = e_acc && (m_S != 0) && (n > m_K) && (((n - m_K) % m_S) == 0);
        check("pix_ready", int'(bus.ONEDCONV_SCHED_Pix_Ready), int'(e_rdy));
        check("conv_en",   int'(bus.ONEDCONV_SCHED_Conv_En), int'(e_acc));
        check("eqcw",      int'(bus.ONEDCONV_SCHED_Eqcw), int'(e_cw));
        check("eqst",      int'(bus.ONEDCONV_SCHED_Eqst), int'(e_st));
        check("conv_clr",  int'(bus.ONEDCONV_SCHED_Conv_Clr), int'(m_phase != P_CLR));
        check("busy",      int'(bus.ONEDCONV_SCHED_Busy), int'(m_phase != P_IDLE));
        check("done",      int'(bus.ONEDCONV_SCHED_Done), int'(m_phase == P_DONE));
        check("err",       int'(bus.ONEDCONV_SCHED_Err), int'(m_err));
        if (m_phase != P_CALC)
          check("of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), m_of);
`ifdef ONEDCONV_SCHED_ROWCNT_EN
        check("row_idx", int'(bus.ONEDCONV_SCHED_Row_Idx), m_row);
`endif
        cnt_eqcw    += int'(bus.ONEDCONV_SCHED_Eqcw);
        cnt_eqst    += int'(bus.ONEDCONV_SCHED_Eqst);
        cnt_done    += int'(bus.ONEDCONV_SCHED_Done);
        cnt_clr     += int'(!bus.ONEDCONV_SCHED_Conv_Clr);
        cnt_en      += int'(bus.ONEDCONV_SCHED_Conv_En);
        cnt_rdy     += int'(bus.ONEDCONV_SCHED_Pix_Ready);
        cnt_en_full += int'(bus.ONEDCONV_SCHED_Conv_En && bus.ONEDCONV_SCHED_Out_Full);
        cnt_busy    += int'(bus.ONEDCONV_SCHED_Busy);
        cnt_calc    += int'(bus.ONEDCONV_SCHED_Busy && bus.ONEDCONV_SCHED_Conv_Clr &&
                            !bus.ONEDCONV_SCHED_Done && !bus.ONEDCONV_SCHED_Pix_Ready);
        // advance the model to what the coming rising edge produces
        case (m_phase)
          P_IDLE: if (bus.ONEDCONV_SCHED_Start) begin
            m_C = int'(bus.ONEDCONV_SCHED_Img_Colums);
            m_K = int'(bus.ONEDCONV_SCHED_Kernel_W);
            m_S = int'(bus.ONEDCONV_SCHED_Stride);
`ifdef ONEDCONV_SCHED_ROWCNT_EN
            m_R = int'(bus.ONEDCONV_SCHED_Rows);
`else
            m_R = 1;
`endif
            m_err   = 1'b0;
            m_row   = 0;
            m_valid = (m_K != 0) && (m_S != 0) && (m_C >= m_K) && (m_R != 0);
            m_left  = m_valid ? ((m_C - m_K) / m_S + 1) : 1;
            m_phase = P_CALC;
          end
          P_CALC: begin
            m_left--;
            if (m_left == 0) begin
              if (m_valid) begin
                m_of = (m_C - m_K) / m_S + 1;
                m_phase = P_CLR;
              end else begin
                m_of = 0; m_err = 1'b1; m_phase = P_DONE;
              end
            end
          end
          P_CLR: begin
            m_acc = 0; m_phase = P_RUN;
          end
          P_RUN: if (e_acc) begin
            m_acc++;
            if (m_acc == m_C) begin
              if (m_row == m_R - 1) m_phase = P_DONE;
              else begin m_row++; m_phase = P_CLR; end
            end
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  int b_cw, b_st, b_done, b_clr, b_en, b_rdy, b_enf, b_calc, b_busy;

  task automatic snap();
    b_cw = cnt_eqcw; b_st = cnt_eqst; b_done = cnt_done; b_clr = cnt_clr; b_en = cnt_en;
    b_rdy = cnt_rdy; b_enf = cnt_en_full; b_calc = cnt_calc; b_busy = cnt_busy;
  endtask

  task automatic set_cfg(input int c, input int k, input int s, input int r);
    bus.ONEDCONV_SCHED_Img_Colums = CW'(c);
    bus.ONEDCONV_SCHED_Kernel_W   = KW'(k);
    bus.ONEDCONV_SCHED_Stride     = KW'(s);
`ifdef ONEDCONV_SCHED_ROWCNT_EN
    bus.ONEDCONV_SCHED_Rows       = RW'(r);
`else
    if (r < 0) bus.ONEDCONV_SCHED_Stride = KW'(s);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode 0: continuous valid; 1: continuous with a 4-cycle Out_Full stall; 2: random
  task automatic run_row(input int c, input int k, input int s, input int r, input int mode);
    int i;
    @(posedge clk); #1;
    set_cfg(c, k, s, r);
    bus.ONEDCONV_SCHED_Start = 1'b1;
    bus.ONEDCONV_SCHED_Pix_Valid = 1'b0;
    bus.ONEDCONV_SCHED_Out_Full = 1'b0;
    i = 0;
    forever begin
      @(posedge clk); #1;
      if (!bus.ONEDCONV_SCHED_Busy) begin
        bus.ONEDCONV_SCHED_Start = 1'b0;
        bus.ONEDCONV_SCHED_Pix_Valid = 1'b0;
        bus.ONEDCONV_SCHED_Out_Full = 1'b0;
        break;
      end
      if (i >= 400) begin
        n_chk++; n_fail++;
        $display("FAIL row_timeout: still busy after %0d cycles, expected idle", i);
        bus.ONEDCONV_SCHED_Start = 1'b0;
        do_reset();
        break;
      end
      if (mode == 2) begin
        bus.ONEDCONV_SCHED_Start = (($urandom % 8) == 0);
        set_cfg($urandom_range(0, 2047), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        bus.ONEDCONV_SCHED_Pix_Valid = (($urandom % 4) != 0);
        bus.ONEDCONV_SCHED_Out_Full  = (($urandom % 5) == 0);
      end else begin
        bus.ONEDCONV_SCHED_Start = 1'b0;
        bus.ONEDCONV_SCHED_Pix_Valid = 1'b1;
        bus.ONEDCONV_SCHED_Out_Full = (mode == 1) && (i >= 9) && (i <= 12);
      end
      i++;
    end
  endtask

  initial begin : stim
    int guard;
    int r;
    bus.ONEDCONV_SCHED_Start = 1'b0;
    bus.ONEDCONV_SCHED_Pix_Valid = 1'b0;
    bus.ONEDCONV_SCHED_Out_Full = 1'b0;
    set_cfg(0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("init_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 0);
    check("init_conv_clr",  int'(bus.ONEDCONV_SCHED_Conv_Clr), 1);
    check("init_busy",      int'(bus.ONEDCONV_SCHED_Busy), 0);

    // K=3 S=1 C=8, continuous
    snap(); run_row(8, 3, 1, 1, 0);
    check("t1_of_colums",  int'(bus.ONEDCONV_SCHED_Of_Colums), 6);
    check("t1_calc_cycles", cnt_calc - b_calc, 6);
    check("t1_eqcw",  cnt_eqcw - b_cw, 1);
    check("t1_eqst",  cnt_eqst - b_st, 5);
    check("t1_done",  cnt_done - b_done, 1);
    check("t1_clr",   cnt_clr - b_clr, 1);
    check("t1_row_time", cnt_busy - b_busy, 16);

    // K=3 S=2 C=9
    snap(); run_row(9, 3, 2, 1, 0);
    check("t2_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 4);
    check("t2_eqcw", cnt_eqcw - b_cw, 1);
    check("t2_eqst", cnt_eqst - b_st, 3);
    check("t2_done", cnt_done - b_done, 1);

    // K=3 S=1 C=8 with a 4-cycle Out_Full stall mid-row
    snap(); run_row(8, 3, 1, 1, 1);
    check("t3_eqcw", cnt_eqcw - b_cw, 1);
    check("t3_eqst", cnt_eqst - b_st, 5);
    check("t3_en_during_full", cnt_en_full - b_enf, 0);
    check("t3_row_time", cnt_busy - b_busy, 20);

    // invalid configurations, then a valid one clears Err
    snap(); run_row(8, 0, 1, 1, 0);
    check("t4a_err", int'(bus.ONEDCONV_SCHED_Err), 1);
    check("t4a_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 0);
    run_row(8, 3, 0, 1, 0);
    check("t4b_err", int'(bus.ONEDCONV_SCHED_Err), 1);
    run_row(2, 3, 1, 1, 0);
    check("t4c_err", int'(bus.ONEDCONV_SCHED_Err), 1);
    check("t4c_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 0);
    check("t4_done", cnt_done - b_done, 3);
    check("t4_ready", cnt_rdy - b_rdy, 0);
    run_row(8, 3, 1, 1, 0);
    check("t4_err_cleared", int'(bus.ONEDCONV_SCHED_Err), 0);
    check("t4_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 6);

    // reset after accept 4 of an 8-pixel row
    snap();
    @(posedge clk); #1;
    set_cfg(8, 3, 1, 1);
    bus.ONEDCONV_SCHED_Start = 1'b1;
    guard = 0;
    forever begin
      @(posedge clk); #1;
      bus.ONEDCONV_SCHED_Start = 1'b0;
      bus.ONEDCONV_SCHED_Pix_Valid = 1'b1;
      if (cnt_en - b_en >= 4) break;
      if (guard >= 100) begin
        n_chk++; n_fail++;
        $display("FAIL t5_wait_accepts: got %0d accepts, expected 4", cnt_en - b_en);
        break;
      end
      guard++;
    end
    rst_n = 1'b0;
    bus.ONEDCONV_SCHED_Pix_Valid = 1'b0;
    #1;
    check("t5_pix_ready", int'(bus.ONEDCONV_SCHED_Pix_Ready), 0);
    check("t5_busy", int'(bus.ONEDCONV_SCHED_Busy), 0);
    check("t5_conv_clr", int'(bus.ONEDCONV_SCHED_Conv_Clr), 1);
    check("t5_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t5_no_done", cnt_done - b_done, 0);
    snap(); run_row(8, 3, 1, 1, 0);
    check("t5_rerun_of", int'(bus.ONEDCONV_SCHED_Of_Colums), 6);
    check("t5_rerun_eqst", cnt_eqst - b_st, 5);
    check("t5_rerun_done", cnt_done - b_done, 1);

`ifdef ONEDCONV_SCHED_ROWCNT_EN
    // three rows K=2 S=1 C=4
    snap(); run_row(4, 2, 1, 3, 0);
    check("t6_clr", cnt_clr - b_clr, 3);
    check("t6_eqcw", cnt_eqcw - b_cw, 3);
    check("t6_eqst", cnt_eqst - b_st, 6);
    check("t6_done", cnt_done - b_done, 1);
    check("t6_row_idx", int'(bus.ONEDCONV_SCHED_Row_Idx), 2);
    check("t6_of_colums", int'(bus.ONEDCONV_SCHED_Of_Colums), 3);
`endif

    // randomized rows, checked cycle by cycle by the model
    for (int t = 0; t < 40; t++) begin
`ifdef ONEDCONV_SCHED_ROWCNT_EN
      r = $urandom_range(0, 3);
`else
      r = 1;
`endif
      run_row($urandom_range(0, 20), $urandom_range(0, 5), $urandom_range(0, 4), r, 2);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/onedconv_sched.md
# onedconv_sched

Row scheduler for the one-dimensional convolution datapath. It latches a row configuration (input columns, kernel width, stride) and computes the number of output columns by iterative subtraction. It then paces pixel intake with a valid/ready handshake and drives the set-enable block's enable, window-full (Eqcw), stride (Eqst), clear and output-count inputs. It sits between the pixel source/DMA front end and the convolution set-enable block, and stalls on downstream output-buffer full.

## Interface
- BITWIDTH_OF_COLUMS, 11, width of column counts and Of_Colums
- BITWIDTH_OF_KERNEL, 3, width of kernel-width and stride fields
- BITWIDTH_OF_ROWS, 11, width of row count (used only with ONEDCONV_SCHED_ROWCNT_EN)

Ports:
- ONEDCONV_SCHED_clk  in  1  sole clock, rising edge
- ONEDCONV_SCHED_Clr  in  1  reset, asynchronous, active-low
- ONEDCONV_SCHED_Start  in  1  one-cycle start pulse; ignored unless IDLE
- ONEDCONV_SCHED_Img_Colums  in  BITWIDTH_OF_COLUMS  input pixels per row
- ONEDCONV_SCHED_Kernel_W  in  BITWIDTH_OF_KERNEL  kernel width K
- ONEDCONV_SCHED_Stride  in  BITWIDTH_OF_KERNEL  stride S
- ONEDCONV_SCHED_Pix_Valid  in  1  source presents a pixel
- ONEDCONV_SCHED_Out_Full  in  1  downstream output buffer full
- ONEDCONV_SCHED_Pix_Ready  out  1  scheduler accepts a pixel this cycle
- ONEDCONV_SCHED_Conv_En  out  1  datapath shift enable (= accept)
- ONEDCONV_SCHED_Eqcw  out  1  first window complete
- ONEDCONV_SCHED_Eqst  out  1  stride boundary reached
- ONEDCONV_SCHED_Conv_Clr  out  1  active-low synchronous clear to datapath
- ONEDCONV_SCHED_Of_Colums  out  BITWIDTH_OF_COLUMS  computed output columns
- ONEDCONV_SCHED_Busy  out  1  high outside IDLE
- ONEDCONV_SCHED_Done  out  1  one-cycle pulse at row/frame completion
- ONEDCONV_SCHED_Err  out  1  sticky invalid-config flag; cleared by next accepted Start

## Operation
- Accept = Pix_Valid & Pix_Ready. Pix_Ready = (state==RUN) & !Out_Full. This signal is combinational, and Conv_En equals accept.
- States: IDLE, CALC, CLR, RUN, DONE.
- IDLE: Start latches C, K and S, clears Err and goes to CALC.
- CALC, invalid config: if K==0, S==0 or C<K, set Err, set Of_Colums=0 and go to DONE.
- CALC, valid config: set rem=C-K and Of=1. Each cycle while rem>=S: rem-=S, Of+=1. When rem<S, go to CLR. Of_Colums holds the result until the next Start.
- CLR: Conv_Clr is low for exactly one cycle. Column counter col and stride counter st are zeroed. Go to RUN.
- RUN: each accept increments col. Eqcw = accept & (col==K-1).
- RUN, stride counter: st is active once col>=K. It increments on accept and wraps at S-1. Eqst = accept & (col>=K) & (st==S-1).
- RUN, exit: the accept with col==C-1 moves the FSM to DONE. Trailing pixels past the last window are consumed without Eqst.
- DONE: Done is high for one cycle. Go to IDLE.
- Out_Full high: Pix_Ready is low and all counters hold. The state is unchanged.
- Start outside IDLE is ignored. Config inputs are don't-care after the latch.
- Counter arithmetic is unsigned, in BITWIDTH_OF_COLUMS bits. No wrap occurs because C fits in that width.

## Timing
- Reset (async assert, sync deassert via next clk edge) values:
  - state=IDLE
  - Pix_Ready=0, Conv_En=0, Eqcw=0, Eqst=0
  - Conv_Clr=1
  - Of_Colums=0
  - Busy=0, Done=0, Err=0
- Reset mid-row aborts immediately. No Done pulse is produced.
- Start at edge n: CALC from n+1, for floor((C-K)/S)+1 cycles.
- CLR lasts one cycle. After it, the first Pix_Ready can be high.
- Eqcw and Eqst are combinational, in the same cycle as the qualifying accept. They are aligned with Conv_En for sampling by the set-enable block.
- Done is asserted the cycle after the final accept.
- Busy falls in the same cycle Done falls.
- Minimum row time = CALC + 1 + C + 1 cycles when Pix_Valid is continuous and Out_Full is low.

## Configuration
- ONEDCONV_SCHED_ROWCNT_EN defined: adds input ONEDCONV_SCHED_Rows (BITWIDTH_OF_ROWS) and output ONEDCONV_SCHED_Row_Idx (BITWIDTH_OF_ROWS).
  - Rows is latched at Start.
  - Leaving RUN goes to CLR for the next row, with Row_Idx+1, until Row_Idx==Rows-1. Only then does the FSM go to DONE.
  - Of_Colums is not recomputed between rows.
  - Rows==0 sets Err.
  - Row_Idx resets to 0.
- Undefined: single row per Start. No Rows or Row_Idx ports.

## Test plan
- K=3, S=1, C=8, continuous valid:
  - Of_Colums=6 after 6 CALC cycles.
  - Eqcw on accept 3. Eqst on accepts 4..8 (5 pulses).
  - Done 1 cycle after accept 8.
- K=3, S=2, C=9: Of_Colums=4. Eqcw on accept 3. Eqst on accepts 5, 7, 9.
- K=3, S=1, C=8 with Out_Full high for 4 cycles mid-row: Pix_Ready=0 and no Conv_En/Eqst during the stall. Totals are unchanged (1 Eqcw, 5 Eqst).
- Invalid configs K=0, S=0, or C=2 with K=3: Err=1, Of_Colums=0, Done pulse, no Pix_Ready. The next valid Start clears Err.
- Clr low after accept 4 of an 8-pixel row: all outputs at reset values, no Done. A new Start then runs a full row correctly.
- With ONEDCONV_SCHED_ROWCNT_EN, Rows=3, K=2, S=1, C=4:
  - 3 Conv_Clr low pulses.
  - Row_Idx 0→1→2.
  - 3 Eqcw, 6 Eqst total.
  - Single Done.
